aes256_inv_key_sched: RTL and testbench
=======================================

AES256_INV_KEY_SCHED -- requirements
Module: aes256_inv_key_sched

Interface
REQ-001 SHALL have parameter none; all widths fixed for AES-256 (Nk=8, Nr=14).
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-004 start_v_i  input  1  load request; key_i sampled when start_v_i & ready_o.
REQ-005 key_i  input  256  final expanded window w52..w59; key_i[255:224]=w52, key_i[31:0]=w59.
REQ-006 ready_o  output  1  block idle, start accepted.
REQ-007 v_o  output  1  rk_o/round_o valid.
REQ-008 yumi_i  input  1  consumer takes current output; legal only when v_o=1.
REQ-009 rk_o  output  128  round key r = {w(4r),w(4r+1),w(4r+2),w(4r+3)}, w(4r) in [127:96].
REQ-010 round_o  output  4  round index r of rk_o, 14 down to 0.
REQ-011 last_o  output  1  high with v_o when round_o=0.

Function
REQ-012 SHALL have two states: IDLE (ready_o=1, v_o=0) and RUN (ready_o=0, v_o=1).
REQ-013 IDLE->RUN on start_v_i; window register <= key_i, round counter <= 14.
REQ-014 In RUN, rk_o SHALL be the upper-index half of the window (w(4r)..w(4r+3)), output straight from registers.
REQ-015 First valid output (round 14) SHALL appear the cycle after start acceptance; no other latency.
REQ-016 On yumi_i with round_o>0: window shifts back 4 words, counter decrements, v_o stays 1; one round key per cycle sustained.
REQ-017 Backward step for window top index i (i = 4r+3 down to 4r): w(i-8) = w(i) XOR f(w(i-1)), all four words computed in parallel from the current window.
REQ-018 f = SubWord(RotWord(x)) XOR {Rcon(i/8),24'h0} when i mod 8 = 0; SubWord(x) when i mod 8 = 4; identity otherwise.
REQ-019 RotWord SHALL move byte [31:24] to [7:0]; Rcon(j) = 8'h01 << (j-1), j = 1..7; no reduction needed.
REQ-020 On yumi_i with round_o=0: RUN->IDLE next cycle, ready_o=1 then.
REQ-021 start_v_i in RUN SHALL be ignored; no restart mid-sequence.
REQ-022 v_o held without yumi_i SHALL keep rk_o/round_o/last_o stable indefinitely.
REQ-023 Simultaneous yumi_i on round 0 and start_v_i: start ignored that cycle (ready_o=0).

Reset
REQ-024 reset_n_i low SHALL immediately force IDLE, ready_o=1, v_o=0, last_o=0, round_o=0, rk_o=0, window=0.
REQ-025 Reset mid-RUN SHALL abandon the sequence; no output after release until a new start.

Configuration
REQ-026 Macro AES_INV_KS_ZEROIZE_EN: when defined, window register and rk_o SHALL be cleared to 0 on the RUN->IDLE transition; when undefined, they retain the round 0 key in IDLE (v_o=0).

Structure
REQ-027 Shared package aes_pkg SHALL hold Nk, Nr, word/key width constants, the Rcon table and the state enum.
REQ-028 One sub-module aes_sub_word (four existing rom_sbox instances, 32-bit in/out) SHALL be used once per step; selection between the i mod 8 = 0 and 4 word feeds it.

Verification
REQ-029 Reset then FIPS-197 C.3 key (000102..1f) window w52..w59 with start_v_i -> cycle+1 v_o=1, round_o=14, rk_o=24fc79ccbf0979e9371ac23c6d68de36.
REQ-030 Same load, yumi_i held high -> 15 consecutive outputs, round_o 14..0, final rk_o=000102030405060708090a0b0c0d0e0f with last_o=1, then ready_o=1.
REQ-031 yumi_i withheld 5 cycles at round 7 -> rk_o/round_o unchanged for all 5 cycles; sequence continues correctly after.
REQ-032 start_v_i pulsed with a different key at round 10 -> ignored; output sequence matches original key.
REQ-033 reset_n_i low at round 5 (asynchronous, mid-cycle) -> outputs 0 immediately, ready_o=1; new load restarts at round 14.
REQ-034 Random 256-bit keys: forward-expand in the model, load w52..w59 -> all 15 rk_o match; with AES_INV_KS_ZEROIZE_EN, rk_o=0 after return to IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and types for the AES-256 inverse key schedule.
// Holds the AES-256 key-schedule dimensions, word/key widths, the round
// constant table, the scheduler state enum and the RotWord helper.
package aes_pkg;

  localparam int NK      = 8;    // key length in 32-bit words
  localparam int NR      = 14;   // number of rounds
  localparam int WORD_W  = 32;
  localparam int KEY_W   = NK * WORD_W;   // 256
  localparam int BLOCK_W = 4 * WORD_W;    // 128, one round key
  localparam int ROUND_W = 4;

  localparam logic [ROUND_W-1:0] TOP_ROUND = ROUND_W'(NR);

  // Rcon(j) for j = 1..7; entry 0 is unused and held at zero.
  // Rcon(j) is 8'h01 << (j-1) over this range, so no reduction is needed.
  localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // RotWord: byte [31:24] moves to [7:0].
  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes256_inv_key_sched_if.sv
// Load / round-key stream interface of the AES-256 inverse key schedule.
//   start_v_i, key_i : load request and final window w52..w59
//   ready_o          : scheduler idle, a load is accepted
//   v_o, yumi_i      : round key valid / consumer takes it
//   rk_o, round_o    : round key and its round index (14 down to 0)
//   last_o           : valid output is round 0
// Modports: master = key source and consumer, slave = scheduler.
interface aes256_inv_key_sched_if;
  import aes_pkg::*;

  logic                 start_v_i;
  logic [KEY_W-1:0]     key_i;
  logic                 ready_o;
  logic                 v_o;
  logic                 yumi_i;
  logic [BLOCK_W-1:0]   rk_o;
  logic [ROUND_W-1:0]   round_o;
  logic                 last_o;

  modport master (
    output start_v_i, key_i, yumi_i,
    input  ready_o, v_o, rk_o, round_o, last_o
  );

  modport slave (
    input  start_v_i, key_i, yumi_i,
    output ready_o, v_o, rk_o, round_o, last_o
  );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   word : input word
//   sub  : byte-wise S-box substitution of word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sub
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    rom_sbox u_sbox (
      .addr (word[8*b +: 8]),
      .data (sub[8*b +: 8])
    );
  end

endmodule

// File: rtl/rom_sbox.sv
// AES forward S-box as a 256-entry combinational lookup.
//   addr : input byte
//   data : SubBytes(addr)
module rom_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data = SBOX[addr];

endmodule

// File: rtl/aes256_inv_key_sched.sv
// AES-256 inverse key schedule. Loads the last expanded window w52..w59 and
// streams round keys 14 down to 0, one per accepted cycle, by running the
// key expansion backwards: w(i-8) = w(i) ^ f(w(i-1)).
//
// Ports:
//   clk_i     : clock, all state on the rising edge
//   reset_n_i : asynchronous active-low reset
//   ks        : load / round-key stream interface (slave modport)
//
// Build option: define AES_INV_KS_ZEROIZE_EN to clear the window and rk_o
// when the sequence finishes; otherwise round key 0 stays visible in IDLE.
module aes256_inv_key_sched
  import aes_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  aes256_inv_key_sched_if.slave  ks
);

  state_e               state_q, state_d;
  logic [KEY_W-1:0]     window_q, window_d;
  logic [ROUND_W-1:0]   round_q, round_d;

  // win[k] = w(4r-4+k) for current round r; win[4..7] is round key r.
  logic [WORD_W-1:0]    win [8];
  for (genvar k = 0; k < 8; k++) begin : g_win
    assign win[k] = window_q[KEY_W-1-WORD_W*k -: WORD_W];
  end

  // Only the new lowest word w(4r-8) needs f(); its feed index i = 4r has
  // i mod 8 = 0 on even rounds (RotWord + Rcon) and 4 on odd rounds.
  logic                 even_round;
  logic [WORD_W-1:0]    sub_in, sub_out, rcon_word;
  logic [KEY_W-1:0]     step_window;

  assign even_round = ~round_q[0];
  assign sub_in     = even_round ? rot_word(win[3]) : win[3];
  assign rcon_word  = even_round ? {RCON[round_q[3:1]], 24'h0} : '0;

  aes_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  // Next window w(4r-8)..w(4r-1) followed by the old lower half.
  assign step_window = {win[4] ^ sub_out ^ rcon_word,
                        win[5] ^ win[4],
                        win[6] ^ win[5],
                        win[7] ^ win[6],
                        win[0], win[1], win[2], win[3]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d  = state_q;
    window_d = window_q;
    round_d  = round_q;
    case (state_q)
      ST_IDLE: begin
        if (ks.start_v_i) begin
          state_d  = ST_RUN;
          window_d = ks.key_i;
          round_d  = TOP_ROUND;
        end
      end
      ST_RUN: begin
        // start_v_i is not looked at here: no restart mid-sequence.
        if (ks.yumi_i) begin
          if (round_q == '0) begin
            state_d = ST_IDLE;
`ifdef AES_INV_KS_ZEROIZE_EN
            window_d = '0;
`else
            window_d = window_q;
`endif
          end else begin
            window_d = step_window;
            round_d  = round_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  // NOTE: the window is a plain register, so it is cleared in reset to give
  // a defined rk_o while idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      window_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      round_q  <= round_d;
    end
  end

  assign ks.ready_o = (state_q == ST_IDLE);
  assign ks.v_o     = (state_q == ST_RUN);
  assign ks.rk_o    = window_q[BLOCK_W-1:0];
  assign ks.round_o = round_q;
  assign ks.last_o  = (state_q == ST_RUN) && (round_q == '0);

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Self-checking bench for aes256_inv_key_sched. A reference forward key
// expansion (S-box derived from GF(2^8) arithmetic) supplies the loaded
// window and the expected round keys; FIPS-197 C.3 round keys 14 and 0 are
// also checked against literal constants.
module tb_aes256_inv_key_sched;

  logic clk_i = 1'b0;
  logic reset_n_i;
  always #5 clk_i = ~clk_i;

  aes256_inv_key_sched_if ks ();

  aes256_inv_key_sched dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .ks        (ks)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m [256];
  logic [31:0] w_m [60];
  logic [255:0] win_m;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_m(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w_m[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w_m[i-1];
      if (i % 8 == 0) begin
        t = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_m(t);
      end
      w_m[i] = w_m[i-8] ^ t;
    end
    for (int i = 0; i < 8; i++) win_m[255-32*i -: 32] = w_m[52+i];
  endtask

  function automatic logic [127:0] rk_m(input int r);
    return {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endfunction

  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_ALT = 256'hdeadbeef0badf00dcafebabe123456789abcdef0fedcba9876543210a5a5a5a5;
  localparam logic [127:0] RK14_C3 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK0_C3  = 128'h000102030405060708090a0b0c0d0e0f;

  // Load key, then consume all 15 round keys. Optional: hold yumi for 5
  // cycles at hold_r, pulse start with another key at pulse_r, and raise
  // start together with the final yumi.
  task automatic run_key(input logic [255:0] key, input int hold_r, input int pulse_r,
                         input bit start_at_end, input bit fips, input string tag);
    logic [127:0] exp_idle;
    expand(key);
    check({tag, ".ready_pre"}, 128'(ks.ready_o), 128'd1);
    ks.start_v_i = 1'b1;
    ks.key_i     = win_m;
    @(negedge clk_i);
    ks.start_v_i = 1'b0;
    ks.key_i     = '0;
    check({tag, ".ready_run"}, 128'(ks.ready_o), 128'd0);
    for (int r = 14; r >= 0; r--) begin
      check($sformatf("%s.r%0d.v", tag, r), 128'(ks.v_o), 128'd1);
      check($sformatf("%s.r%0d.round", tag, r), 128'(ks.round_o), 128'(r));
      check($sformatf("%s.r%0d.rk", tag, r), ks.rk_o, rk_m(r));
      check($sformatf("%s.r%0d.last", tag, r), 128'(ks.last_o), 128'(r == 0));
      if (fips && r == 14) check({tag, ".fips_rk14"}, ks.rk_o, RK14_C3);
      if (fips && r == 0)  check({tag, ".fips_rk0"}, ks.rk_o, RK0_C3);
      if (r == hold_r) begin
        ks.yumi_i = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk_i);
          check($sformatf("%s.hold%0d.round", tag, h), 128'(ks.round_o), 128'(r));
          check($sformatf("%s.hold%0d.rk", tag, h), ks.rk_o, rk_m(r));
          check($sformatf("%s.hold%0d.v", tag, h), 128'(ks.v_o), 128'd1);
        end
      end
      ks.yumi_i = 1'b1;
      if (r == pulse_r || (r == 0 && start_at_end)) begin
        ks.start_v_i = 1'b1;
        ks.key_i     = KEY_ALT;
      end
      @(negedge clk_i);
      ks.yumi_i    = 1'b0;
      ks.start_v_i = 1'b0;
      ks.key_i     = '0;
    end
`ifdef AES_INV_KS_ZEROIZE_EN
    exp_idle = '0;
`else
    exp_idle = rk_m(0);
`endif
    check({tag, ".end.ready"}, 128'(ks.ready_o), 128'd1);
    check({tag, ".end.v"}, 128'(ks.v_o), 128'd0);
    check({tag, ".end.last"}, 128'(ks.last_o), 128'd0);
    check({tag, ".end.rk"}, ks.rk_o, exp_idle);
  endtask

  initial begin
    reset_n_i    = 1'b0;
    ks.start_v_i = 1'b0;
    ks.key_i     = '0;
    ks.yumi_i    = 1'b0;
    build_sbox();

    #3;
    check("rst.ready", 128'(ks.ready_o), 128'd1);
    check("rst.v", 128'(ks.v_o), 128'd0);
    check("rst.last", 128'(ks.last_o), 128'd0);
    check("rst.round", 128'(ks.round_o), 128'd0);
    check("rst.rk", ks.rk_o, 128'd0);

    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Straight run of the FIPS-197 C.3 key.
    run_key(KEY_C3, -1, -1, 1'b0, 1'b1, "c3");
    // Stall at round 7, ignored start at round 10 and at the final yumi.
    run_key(KEY_C3, 7, 10, 1'b1, 1'b1, "stall");

    // Asynchronous reset mid-sequence at round 5.
    expand(KEY_C3);
    ks.start_v_i = 1'b1;
    ks.key_i     = win_m;
    @(negedge clk_i);
    ks.start_v_i = 1'b0;
    ks.key_i     = '0;
    ks.yumi_i    = 1'b1;
    repeat (9) @(negedge clk_i);
    check("arst.pre_round", 128'(ks.round_o), 128'd5);
    ks.yumi_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst.ready", 128'(ks.ready_o), 128'd1);
    check("arst.v", 128'(ks.v_o), 128'd0);
    check("arst.last", 128'(ks.last_o), 128'd0);
    check("arst.round", 128'(ks.round_o), 128'd0);
    check("arst.rk", ks.rk_o, 128'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("arst.post%0d.v", c), 128'(ks.v_o), 128'd0);
      check($sformatf("arst.post%0d.ready", c), 128'(ks.ready_o), 128'd1);
    end
    run_key(KEY_C3, -1, -1, 1'b0, 1'b1, "reload");

    // Random keys through the reference expansion.
    for (int k = 0; k < 3; k++) begin
      logic [255:0] rkey;
      rkey = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
      run_key(rkey, -1, -1, 1'b0, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
